spi_xfer_queue: RTL and testbench

Word-level transfer queue that sits directly upstream of the SPI host core. It sits between the bus-facing register logic and the core's register port. It accepts TX words on a valid/ready stream and buffers them in a TX FIFO. For each word it programs the core's TX_0 and CTRL registers, waits for the core's end-of-character interrupt, reads RX_0 back, and pushes the received word into an RX FIFO. Software can then stream characters without polling GO.

---
 rtl/spi_xfer_pkg.sv | 27 ++
 rtl/spi_xfer_fifo.sv | 69 ++++++
 rtl/spi_xfer_queue.sv | 215 +++++++++++++++++++++
 tb/tb_spi_xfer_queue.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI transfer queue.
// Holds the FSM state type, the SPI host core register offsets, the GO bit
// position and the width of the WAIT-state timeout counter.
package spi_xfer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadTx,
    StStart,
    StWait,
    StRdAddr,
    StRdCap
  } xfer_state_e;

  localparam logic [7:0]  SPI_XQ_OFS_DATA = 8'h00;
  localparam logic [7:0]  SPI_XQ_OFS_CTRL = 8'h10;
  localparam int unsigned SPI_XQ_GO_BIT   = 8;
  localparam int unsigned SPI_XQ_CNT_W    = 16;

  // CTRL write data with GO forced high, whatever the caller supplied in bit 8.
  function automatic logic [31:0] ctrl_with_go(input logic [15:0] ctrl);
    logic [15:0] go_mask;
    go_mask = 16'h0001 << SPI_XQ_GO_BIT;
    return {16'h0000, ctrl | go_mask};
  endfunction

endpackage

// File: rtl/spi_xfer_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   push_i, wdata_i  write side; a push while full is dropped
//   pop_i, rdata_o   read side; rdata_o is the head, a pop while empty is dropped
//   full_o, empty_o  occupancy flags
//   level_o          number of stored entries (0..Depth)
// Depth must be a power of two so the pointers wrap naturally.
module spi_xfer_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == (PtrW + 1)'(Depth));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: only entries below level_q are ever observed.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_xfer_queue.sv
// Word-level transfer queue in front of the SPI host core register port.
// TX words are buffered, and for each one the block writes TX_0, writes CTRL
// with GO set, waits for the end-of-character interrupt, then (with the RX path)
// reads RX_0 back into an RX FIFO.
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   enable_i                          allows new transfers to start
//   ctrl_word_i                       CTRL value per character (GO forced on)
//   tx_wdata_i/tx_valid_i/tx_ready_o  TX word stream
//   rx_rdata_o/rx_valid_o/rx_ready_i  RX word stream (first-word fall-through)
//   tx_level_o, rx_level_o            FIFO occupancies
//   busy_o                            FSM not idle
//   err_o, err_clr_i                  sticky timeout flag and its clear
//   core_*                            SPI host core register port and interrupts
// Build option: define SPI_XFER_QUEUE_RX_EN to include the RX FIFO and the
// RX_0 read-back states. Without it the RX outputs are tied to zero.
module spi_xfer_queue
  import spi_xfer_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [15:0]               ctrl_word_i,
  input  logic [31:0]               tx_wdata_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [31:0]               rx_rdata_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic [$clog2(DEPTH):0]    tx_level_o,
  output logic [$clog2(DEPTH):0]    rx_level_o,
  output logic                      busy_o,
  output logic                      err_o,
  input  logic                      err_clr_i,
  output logic [7:0]                core_addr_o,
  output logic [31:0]               core_wdata_o,
  output logic [3:0]                core_be_o,
  output logic                      core_we_o,
  output logic                      core_re_o,
  input  logic [31:0]               core_rdata_i,
  input  logic                      core_intr_tx_i,
  input  logic                      core_intr_rx_i
);

  logic [31:0] tx_head;
  logic        tx_full, tx_empty, tx_pop;
  logic        rx_space;

  xfer_state_e             state_q, state_d;
  logic [SPI_XQ_CNT_W-1:0] cnt_q, cnt_d;
  logic [SPI_XQ_CNT_W:0]   cnt_inc;
  logic                    err_q, err_d;
  logic [7:0]              addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic                    we_q, we_d;
  logic                    re_q, re_d;

  // The TX head is popped while its value is already registered on core_wdata_o.
  assign tx_pop = (state_q == StLoadTx);

  spi_xfer_fifo #(
    .Width (32),
    .Depth (DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_valid_i),
    .wdata_i (tx_wdata_i),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level_o)
  );

  assign tx_ready_o = ~tx_full;

`ifdef SPI_XFER_QUEUE_RX_EN
  logic rx_full, rx_empty, rx_push;

  assign rx_push = (state_q == StRdCap);

  spi_xfer_fifo #(
    .Width (32),
    .Depth (DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_push),
    .wdata_i (core_rdata_i),
    .pop_i   (rx_ready_i),
    .rdata_o (rx_rdata_o),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level_o)
  );

  assign rx_valid_o = ~rx_empty;
  assign rx_space   = ~rx_full;
`else
  logic unused_rx;

  assign unused_rx  = ^{rx_ready_i, core_rdata_i};
  assign rx_rdata_o = '0;
  assign rx_valid_o = 1'b0;
  assign rx_level_o = '0;
  assign rx_space   = 1'b1;
`endif

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (err_clr_i) err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable_i && !tx_empty && rx_space) state_d = StLoadTx;
      end
      StLoadTx: state_d = StStart;
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_inc[SPI_XQ_CNT_W-1:0];
        // Interrupt has priority over a timeout landing in the same cycle.
        if (core_intr_tx_i || core_intr_rx_i) begin
`ifdef SPI_XFER_QUEUE_RX_EN
          state_d = StRdAddr;
`else
          state_d = StIdle;
`endif
        end else if (cnt_inc == (SPI_XQ_CNT_W + 1)'(TIMEOUT)) begin
          // Setting wins over a clear arriving in the same cycle.
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
`ifdef SPI_XFER_QUEUE_RX_EN
      StRdAddr: state_d = StRdCap;
      StRdCap:  state_d = StIdle;
`endif
      default:  state_d = StIdle;
    endcase
  end

  // Core port values are decoded from the next state so they are registered
  // alongside it and line up with the state they belong to.
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    be_d    = '0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    unique case (state_d)
      StLoadTx: begin
        addr_d  = SPI_XQ_OFS_DATA;
        wdata_d = tx_head;
        be_d    = 4'hF;
        we_d    = 1'b1;
      end
      StStart: begin
        addr_d  = SPI_XQ_OFS_CTRL;
        wdata_d = ctrl_with_go(ctrl_word_i);
        be_d    = 4'h3;
        we_d    = 1'b1;
      end
`ifdef SPI_XFER_QUEUE_RX_EN
      StRdAddr: begin
        addr_d = SPI_XQ_OFS_DATA;
        re_d   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign err_o        = err_q;
  assign core_addr_o  = addr_q;
  assign core_wdata_o = wdata_q;
  assign core_be_o    = be_q;
  assign core_we_o    = we_q;
  assign core_re_o    = re_q;

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Self-checking bench for spi_xfer_queue. A mock SPI core answers the register
// port: it records the TX_0 word, raises an interrupt a chosen number of cycles
// after the CTRL write, and returns (word ^ 0xFF) on the RX_0 read.
// Build option: SPI_XFER_QUEUE_RX_EN selects the RX-path expectations.
module tb_spi_xfer_queue;

  localparam int unsigned Depth   = 8;
  localparam int unsigned Timeout = 50;
`ifdef SPI_XFER_QUEUE_RX_EN
  localparam bit RxEn = 1'b1;
`else
  localparam bit RxEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic [15:0] ctrl_word_i;
  logic [31:0] tx_wdata_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [31:0] rx_rdata_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic [3:0]  tx_level_o, rx_level_o;
  logic        busy_o, err_o;
  logic        err_clr_i;
  logic [7:0]  core_addr_o;
  logic [31:0] core_wdata_o;
  logic [3:0]  core_be_o;
  logic        core_we_o, core_re_o;
  logic [31:0] core_rdata_i = '0;
  logic        core_intr_tx_i = 1'b0;
  logic        core_intr_rx_i = 1'b0;

  spi_xfer_queue #(
    .DEPTH   (Depth),
    .TIMEOUT (Timeout)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .ctrl_word_i    (ctrl_word_i),
    .tx_wdata_i     (tx_wdata_i),
    .tx_valid_i     (tx_valid_i),
    .tx_ready_o     (tx_ready_o),
    .rx_rdata_o     (rx_rdata_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready_i),
    .tx_level_o     (tx_level_o),
    .rx_level_o     (rx_level_o),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .err_clr_i      (err_clr_i),
    .core_addr_o    (core_addr_o),
    .core_wdata_o   (core_wdata_o),
    .core_be_o      (core_be_o),
    .core_we_o      (core_we_o),
    .core_re_o      (core_re_o),
    .core_rdata_i   (core_rdata_i),
    .core_intr_tx_i (core_intr_tx_i),
    .core_intr_rx_i (core_intr_rx_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_tx[$];      // words accepted, not yet written to TX_0
  logic [31:0] exp_rx[$];      // words read back, not yet popped
  bit          err_exp;
  int unsigned ctrl_writes;
  int unsigned rx_popped;

  // Mock core / protocol monitor state
  bit          m_ctrl_pending, m_waiting, m_rd_expect, m_clr_drive;
  int unsigned m_wait_cnt, m_delay;
  logic [31:0] m_last_word;
  int unsigned fixed_delay;    // 0: random 1..20, >Timeout: never interrupt
  bit          clr_at_timeout;

  // RX consumer controls
  bit pop_en, pop_one;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_ctrl_pending = 0; m_waiting = 0; m_rd_expect = 0; m_clr_drive = 0;
      core_intr_tx_i = 0; core_intr_rx_i = 0; core_rdata_i = '0;
      exp_tx.delete();
      exp_rx.delete();
    end else begin
      core_intr_tx_i = 0;
      core_intr_rx_i = 0;
      if (m_clr_drive) begin
        err_clr_i   = 0;
        m_clr_drive = 0;
      end
      if (m_ctrl_pending) begin
        check_eq("ctrl_we", core_we_o, 1);
        check_eq("ctrl_addr", core_addr_o, 8'h10);
        check_eq("ctrl_be", core_be_o, 4'h3);
        check_eq("ctrl_wdata", core_wdata_o, {16'h0, ctrl_word_i | 16'h0100});
        m_ctrl_pending = 0;
        m_waiting      = 1;
        m_wait_cnt     = 0;
        m_delay        = (fixed_delay != 0) ? fixed_delay : $urandom_range(1, 20);
        ctrl_writes++;
      end else if (m_rd_expect) begin
        m_rd_expect = 0;
        check_eq("rd_re", core_re_o, RxEn);
        check_eq("rd_busy", busy_o, RxEn);
        check_eq("rd_addr_we", {core_addr_o, core_we_o}, 0);
        if (core_re_o) begin
          core_rdata_i = m_last_word ^ 32'hFF;
          exp_rx.push_back(m_last_word ^ 32'hFF);
        end
      end else if (m_waiting) begin
        m_wait_cnt++;
        check_eq("wait_quiet", {core_we_o, core_re_o}, 0);
        if (m_wait_cnt == Timeout + 1) begin
          check_eq("to_err_set", err_o, 1);
          check_eq("to_idle", busy_o, 0);
          err_exp   = 1;
          m_waiting = 0;
        end else begin
          if (m_wait_cnt == Timeout) begin
            check_eq("to_busy_before", busy_o, 1);
            check_eq("to_err_before", err_o, err_exp);
            if (clr_at_timeout) begin
              err_clr_i   = 1;
              m_clr_drive = 1;
            end
          end
          if (m_wait_cnt == m_delay) begin
            if ($urandom_range(0, 1) == 0) core_intr_tx_i = 1;
            else core_intr_rx_i = 1;
            m_waiting   = 0;
            m_rd_expect = 1;
          end
        end
      end else if (core_we_o) begin
        check_eq("data_expected", exp_tx.size() != 0, 1);
        check_eq("data_addr", core_addr_o, 8'h00);
        check_eq("data_be", core_be_o, 4'hF);
        if (exp_tx.size() != 0) begin
          m_last_word = exp_tx.pop_front();
          check_eq("data_wdata", core_wdata_o, m_last_word);
        end
        m_ctrl_pending = 1;
      end else begin
        check_eq("bus_idle", {core_addr_o, core_be_o, core_re_o}, 0);
        check_eq("bus_idle_wdata", core_wdata_o, 0);
      end
`ifndef SPI_XFER_QUEUE_RX_EN
      check_eq("norx_outputs", {rx_valid_o, rx_level_o}, 0);
      check_eq("norx_rdata", rx_rdata_o, 0);
`endif
    end
  end

  // RX consumer: the only driver of rx_ready_i
  always @(negedge clk_i) begin
    bit want;
    if (!rst_ni) begin
      rx_ready_i = 0;
    end else begin
      want = pop_en ? ($urandom_range(0, 3) != 0) : pop_one;
      if (want && rx_valid_o) begin
        check_eq("rx_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) check_eq("rx_word", rx_rdata_o, exp_rx.pop_front());
        rx_popped++;
        pop_one = 0;
      end
      rx_ready_i = want;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit bench_idle();
    return !busy_o && tx_level_o == 0 && !m_waiting && !m_rd_expect && !m_ctrl_pending;
  endfunction

  task automatic push_word(input logic [31:0] w);
    int unsigned guard = 0;
    while (!tx_ready_o && guard < 300) begin
      @(negedge clk_i);
      guard++;
    end
    check_eq("push_ready", tx_ready_o, 1);
    if (tx_ready_o) begin
      tx_valid_i = 1;
      tx_wdata_i = w;
      exp_tx.push_back(w);
    end
    @(negedge clk_i);
    tx_valid_i = 0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned guard = 0;
    while (!bench_idle() && guard < 3000) begin
      @(negedge clk_i);
      guard++;
    end
    check_eq(tag, bench_idle(), 1);
  endtask

  task automatic drain_rx(input string tag);
    int unsigned guard = 0;
    while (exp_rx.size() != 0 && guard < 500) begin
      @(negedge clk_i);
      guard++;
    end
    @(negedge clk_i);
    check_eq(tag, {rx_valid_o, rx_level_o}, 0);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_tx_ready"}, tx_ready_o, 1);
    check_eq({tag, "_rx_valid"}, rx_valid_o, 0);
    check_eq({tag, "_levels"}, {tx_level_o, rx_level_o}, 0);
    check_eq({tag, "_busy_err"}, {busy_o, err_o}, 0);
    check_eq({tag, "_core_ctl"}, {core_addr_o, core_be_o, core_we_o, core_re_o}, 0);
    check_eq({tag, "_core_wdata"}, core_wdata_o, 0);
  endtask

  task automatic pulse_err_clr();
    err_clr_i = 1;
    @(negedge clk_i);
    err_clr_i = 0;
    err_exp   = 0;
    check_eq("err_cleared", err_o, 0);
  endtask

  initial begin
    int unsigned prev, base, guard;
    rst_ni = 0; enable_i = 0; ctrl_word_i = 16'h3608;
    tx_wdata_i = '0; tx_valid_i = 0; err_clr_i = 0;
    err_exp = 0; ctrl_writes = 0; rx_popped = 0;
    fixed_delay = 0; clr_at_timeout = 0; pop_en = 0; pop_one = 0;
    repeat (3) @(negedge clk_i);
    check_reset("rst");
    rst_ni   = 1;
    enable_i = 1;
    @(negedge clk_i);

    // Single word with the documented CTRL value and 20-cycle interrupt delay
    fixed_delay = 20;
    push_word(32'hA5);
    check_eq("lat_cycle1_we", core_we_o, 0);
    @(negedge clk_i);
    check_eq("lat_cycle2_we", core_we_o, 1);
    wait_done("t1_done");
    check_eq("t1_rx_valid", rx_valid_o, RxEn);
    check_eq("t1_rx_level", rx_level_o, RxEn ? 1 : 0);
    check_eq("t1_rx_rdata", rx_rdata_o, RxEn ? 32'h5A : 32'h0);
    pop_one = 1;
    drain_rx("t1_rx_empty");
    pop_one = 0;

    // Back-to-back: fill the TX FIFO while disabled, then drain
    fixed_delay = 0;
    enable_i    = 0;
    ctrl_word_i = 16'($urandom);
    for (int i = 0; i < 8; i++) push_word($urandom);
    check_eq("t2_full_ready", tx_ready_o, 0);
    check_eq("t2_full_level", tx_level_o, 8);
    tx_valid_i = 1;
    tx_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    tx_valid_i = 0;
    check_eq("t2_overflow_level", tx_level_o, 8);
    base     = rx_popped;
    pop_en   = 1;
    enable_i = 1;
    prev     = tx_level_o;
    guard    = 0;
    do begin
      @(negedge clk_i);
      check_eq("t2_tx_level_down", tx_level_o <= prev, 1);
      prev = tx_level_o;
      guard++;
    end while (!bench_idle() && guard < 3000);
    check_eq("t2_drained", bench_idle(), 1);
    drain_rx("t2_rx_empty");
    check_eq("t2_rx_count", rx_popped - base, RxEn ? 8 : 0);

`ifdef SPI_XFER_QUEUE_RX_EN
    // RX backpressure: with RX full the FSM must stay idle
    pop_en = 0;
    @(negedge clk_i);
    for (int i = 0; i < 11; i++) push_word($urandom);
    guard = 0;
    while (!(rx_level_o == 8 && bench_idle_rx()) && guard < 1000) begin
      @(negedge clk_i);
      guard++;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      check_eq("t3_held_idle", busy_o, 0);
    end
    check_eq("t3_tx_level", tx_level_o, 3);
    base    = ctrl_writes;
    pop_one = 1;
    repeat (45) @(negedge clk_i);
    check_eq("t3_one_xfer", ctrl_writes - base, 1);
    check_eq("t3_levels", {tx_level_o, rx_level_o}, {4'd2, 4'd8});
    pop_en = 1;
    wait_done("t3_done");
    drain_rx("t3_rx_empty");
`endif

    // Timeout: no interrupt, no RX push
    pop_en = 0;
    pulse_err_clr();
    fixed_delay = Timeout + 1;
    base        = ctrl_writes;
    push_word($urandom);
    wait_done("t4_done");
    check_eq("t4_ctrl_count", ctrl_writes - base, 1);
    check_eq("t4_no_rx", {rx_valid_o, rx_level_o}, 0);
    check_eq("t4_err", err_o, 1);
    pulse_err_clr();

    // Interrupt landing on the timeout cycle wins
    fixed_delay = Timeout;
    push_word($urandom);
    wait_done("t5_done");
    check_eq("t5_no_err", err_o, 0);
    check_eq("t5_rx_level", rx_level_o, RxEn ? 1 : 0);
    pop_en = 1;
    drain_rx("t5_rx_empty");

    // Clear coinciding with the timeout leaves err set
    pop_en         = 0;
    fixed_delay    = Timeout + 1;
    clr_at_timeout = 1;
    push_word($urandom);
    wait_done("t6_done");
    clr_at_timeout = 0;
    check_eq("t6_err_kept", err_o, 1);
    pulse_err_clr();

    // Dropping enable mid-transfer: current one completes, no new start
    fixed_delay = 0;
    pop_en      = 1;
    base        = ctrl_writes;
    for (int i = 0; i < 3; i++) push_word($urandom);
    guard = 0;
    while (!m_waiting && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    enable_i = 0;
    repeat (60) @(negedge clk_i);
    check_eq("t7_one_xfer", ctrl_writes - base, 1);
    check_eq("t7_tx_level", tx_level_o, 2);
    check_eq("t7_idle", busy_o, 0);
    enable_i = 1;
    wait_done("t7_done");
    check_eq("t7_ctrl_total", ctrl_writes - base, 3);
    drain_rx("t7_rx_empty");

    // Two words: exactly two CTRL writes
    base = ctrl_writes;
    push_word($urandom);
    push_word($urandom);
    wait_done("t8_done");
    check_eq("t8_ctrl_count", ctrl_writes - base, 2);
    drain_rx("t8_rx_empty");

    // Random stream with random CTRL values
    for (int i = 0; i < 12; i++) begin
      if (bench_idle()) ctrl_word_i = 16'($urandom);
      push_word($urandom);
      repeat ($urandom_range(0, 6)) @(negedge clk_i);
    end
    wait_done("t9_done");
    drain_rx("t9_rx_empty");
    check_eq("t9_err", err_o, 0);

    // Reset in the middle of WAIT
    fixed_delay = Timeout + 1;
    push_word($urandom);
    guard = 0;
    while (!(m_waiting && m_wait_cnt >= 5) && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    check_eq("t10_in_wait", busy_o, 1);
    @(posedge clk_i);
    #2;
    rst_ni = 0;
    #1;
    check_reset("mid_rst");
    @(negedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni  = 1;
    err_exp = 0;
    @(negedge clk_i);
    check_reset("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic bit bench_idle_rx();
    return !busy_o && !m_waiting && !m_rd_expect && !m_ctrl_pending;
  endfunction

endmodule
